// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streaming adapter.
// Holds the controller state encoding and the default widths.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int DWIDTH_DEF = 32;
  localparam int CWIDTH_DEF = 32;

endpackage

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry skid buffer: absorbs words arriving from the FIFO read port
// while the downstream sink stalls, and presents the oldest word.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        occ
);

  logic [DWIDTH-1:0] data_p0;
  logic [DWIDTH-1:0] data_p1;
  logic              drain;

  assign out_valid = (occ != 2'd0);
  assign out_data  = data_p0;
  assign drain     = out_valid & out_ready;

  // data_p0 is always the head; data_p1 only holds a word when occ is 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= 2'd0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (in_valid) begin
            data_p0 <= in_data;
            occ     <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && drain) begin
            data_p0 <= in_data;
          end else if (in_valid) begin
            data_p1 <= in_data;
            occ     <= 2'd2;
          end else if (drain) begin
            occ <= 2'd0;
          end
        end
        default: begin
          // The controller never pops into a full buffer unless it also drains.
          if (drain) begin
            data_p0 <= data_p1;
            if (in_valid) data_p1 <= in_data;
            else          occ     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops an unregistered-output BRAM FIFO (1-cycle read latency) and presents
// the words as a valid/ready stream at full rate, with a saturating pop counter.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              busy,
  output logic [CWIDTH-1:0] pop_count
);

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (&v) ? v : v + {{(CWIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e     state;
  logic       inflight_p1;
  logic [1:0] occ;
  logic       drain;
  logic [2:0] load_level;

  assign drain      = m_valid & m_ready;
  assign load_level = {1'b0, occ} + {2'b00, inflight_p1};

  // Pop only while the buffer can still take the word returning next cycle.
  assign fifo_rd_en = (state == ST_RUN) && enable && !fifo_empty &&
                      (load_level <= ({2'b00, drain} + 3'd1));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      inflight_p1 <= 1'b0;
      pop_count   <= '0;
    end else begin
      inflight_p1 <= fifo_rd_en;
      if (fifo_rd_en) pop_count <= sat_inc(pop_count);
      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN:  if (!enable) state <= ST_STOP;
        ST_STOP: begin
          if (enable)                            state <= ST_RUN;
          else if (occ == 2'd0 && !inflight_p1)  state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture stage: fifo_dout is valid exactly one cycle after the pop.
  stream_buf2 #(.DWIDTH(DWIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_p1),
    .in_data   (fifo_dout),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO read port plus a scoreboard of
// loaded words that is checked against every stream handshake.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        m_ready = 1'b0;
  logic [31:0] fifo_dout = 32'h0;

  logic        fifo_rd_en, m_valid, busy;
  logic [31:0] m_data, pop_count;
  logic        rd_en4, m_valid4, busy4;
  logic [31:0] m_data4;
  logic [3:0]  pop_count4;

  logic [31:0] fifo_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] pop_word;
  int          checks = 0;
  int          errors = 0;
  int          n_pops = 0;
  int          pop_base = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_data = 32'h0;

  always #5 clk = ~clk;

  fifo_rd_stream dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy), .pop_count(pop_count)
  );

  fifo_rd_stream #(.DWIDTH(32), .CWIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd_en4), .m_valid(m_valid4),
    .m_ready(m_ready), .m_data(m_data4), .busy(busy4), .pop_count(pop_count4)
  );

  // FIFO read port model: dout follows a pop by one cycle.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      pop_word = fifo_q.pop_front();
      fifo_dout <= pop_word;
      n_pops <= n_pops + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: protocol, counter model and scoreboard on every falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    logic [3:0]  exp_pc4;
    logic [31:0] exp_w;
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      checks++;
      if (fifo_rd_en && fifo_empty) begin
        errors++; $display("FAIL rd_en_while_empty rd_en=%0b empty=%0b", fifo_rd_en, fifo_empty);
      end
      exp_pc  = n_pops - pop_base;
      exp_pc4 = (exp_pc > 32'd15) ? 4'hF : exp_pc[3:0];
      checks++;
      if (pop_count !== exp_pc) begin
        errors++; $display("FAIL pop_count got=%0d want=%0d", pop_count, exp_pc);
      end
      checks++;
      if (pop_count4 !== exp_pc4) begin
        errors++; $display("FAIL pop_count_cw4 got=%0d want=%0d", pop_count4, exp_pc4);
      end
      if (prev_hold) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++; $display("FAIL hold_stable valid=%0b data=%h want_data=%h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL unexpected_beat data=%h want=none", m_data);
        end else begin
          exp_w = sb_q.pop_front();
          if (m_data !== exp_w) begin
            errors++; $display("FAIL beat_data got=%h want=%h", m_data, exp_w);
          end
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    fifo_empty <= 1'b0;
  endtask

  task automatic flush();
    fifo_q.delete();
    sb_q.delete();
    fifo_empty <= 1'b1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sb_q.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 1; m_ready = 1;
    for (int i = 1; i <= 16; i++) load(i);
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (pop_count !== 32'h0) begin errors++; $display("FAIL rst_pop_count got=%0d want=0", pop_count); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b want=0", fifo_rd_en); end
    @(negedge clk); #1;
    rst_n = 1; #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL first_edge_rd_en got=%b want=0", fifo_rd_en); end
  endtask

  task automatic test_basic();
    int first_pop = -1, first_vld = -1, last_beat = -1, beats = 0;
    bit ok;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (first_pop < 0 && fifo_rd_en && !fifo_empty) first_pop = c;
      if (first_vld < 0 && m_valid) first_vld = c;
      if (m_valid && m_ready) begin beats++; last_beat = c; end
    end
    checks++; if (first_vld - first_pop != 2) begin errors++; $display("FAIL first_latency got=%0d want=2", first_vld - first_pop); end
    checks++; if (beats != 16) begin errors++; $display("FAIL basic_beats got=%0d want=16", beats); end
    checks++; if (last_beat - first_vld != 15) begin errors++; $display("FAIL back_to_back span got=%0d want=15", last_beat - first_vld); end
    checks++; if (pop_count !== 32'd16) begin errors++; $display("FAIL basic_pop_count got=%0d want=16", pop_count); end
    tick(); enable = 0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_idle busy=%b want=0", busy); end
  endtask

  task automatic test_stall();
    int base;
    bit ok;
    tick();
    m_ready = 0; enable = 1; base = n_pops;
    for (int i = 1; i <= 16; i++) load(i);
    repeat (20) tick();
    checks++; if (n_pops - base != 2) begin errors++; $display("FAIL stall_pops got=%0d want=2", n_pops - base); end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h1) begin errors++; $display("FAIL stall_head valid=%b data=%h want=1/00000001", m_valid, m_data); end
    m_ready = 1;
    wait_drained(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_drain left=%0d want=0", sb_q.size()); end
    checks++; if (n_pops - base != 16) begin errors++; $display("FAIL stall_total_pops got=%0d want=16", n_pops - base); end
    enable = 0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_idle busy=%b want=0", busy); end
  endtask

  task automatic test_random();
    int pushed = 0;
    bit ok;
    enable = 1;
    for (int c = 0; c < 20000; c++) begin
      if (pushed == 1000 && sb_q.size() == 0) break;
      tick();
      m_ready = ($urandom_range(0, 1) == 1);
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        load($urandom);
        pushed++;
      end
    end
    checks++; if (sb_q.size() != 0 || pushed != 1000) begin errors++; $display("FAIL random_drain left=%0d pushed=%0d want=0/1000", sb_q.size(), pushed); end
    m_ready = 1; enable = 0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_idle busy=%b want=0", busy); end
  endtask

  task automatic test_stop();
    int base;
    bit ok, seen = 0;
    tick();
    m_ready = 0; base = n_pops;
    for (int i = 0; i < 5; i++) load(32'hA0 + i);
    enable = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_valid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stop_first_valid got=0 want=1"); end
    enable = 0;
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy got=%b want=1", busy); end
    checks++; if (n_pops - base != 2) begin errors++; $display("FAIL stop_pops got=%0d want=2", n_pops - base); end
    m_ready = 1;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_idle busy=%b want=0", busy); end
    checks++; if (sb_q.size() != 3 || fifo_q.size() != 3) begin errors++; $display("FAIL stop_leftover sb=%0d fifo=%0d want=3/3", sb_q.size(), fifo_q.size()); end
    repeat (5) tick();
    checks++; if (n_pops - base != 2) begin errors++; $display("FAIL stop_no_more_pops got=%0d want=2", n_pops - base); end
    flush();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    tick();
    m_ready = 0; enable = 1;
    for (int i = 0; i < 10; i++) load(32'hB0 + i);
    repeat (6) tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b want=1", m_valid); end
    #2;
    rst_n = 0; #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", m_valid); end
    checks++; if (pop_count !== 32'h0) begin errors++; $display("FAIL midrst_pop_count got=%0d want=0", pop_count); end
    checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_ctrl busy=%b rd_en=%b want=0/0", busy, fifo_rd_en); end
    pop_base = n_pops;
    flush();
    @(negedge clk); #1;
    rst_n = 1; m_ready = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got=%0d want=0", stale); end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 20; i++) load(32'hC0 + i);
    wait_drained(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_drain left=%0d want=0", sb_q.size()); end
    tick();
    checks++; if (pop_count !== 32'd20) begin errors++; $display("FAIL sat_pop_count got=%0d want=20", pop_count); end
    checks++; if (pop_count4 !== 4'hF) begin errors++; $display("FAIL sat_pop_count_cw4 got=%h want=f", pop_count4); end
    enable = 0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_idle busy=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_stop();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
